// File: rtl/i2s_tx_if.sv
// Sample-side and serial-side signals of the i2s_tx stereo serializer.
// The master drives sample strobes and data. The slave (i2s_tx) returns status and the serial frame.
interface i2s_tx_if #(
  parameter int DATA_WIDTH = 24
);
  logic                         valid;
  logic signed [DATA_WIDTH-1:0] left_in;
  logic signed [DATA_WIDTH-1:0] right_in;
  logic                         ready;
  logic                         busy;
  logic                         bclk;
  logic                         lrck;
  logic                         sdata;
  logic                         overrun;

  modport master (
    output valid, left_in, right_in,
    input  ready, busy, bclk, lrck, sdata, overrun
  );

  modport slave (
    input  valid, left_in, right_in,
    output ready, busy, bclk, lrck, sdata, overrun
  );
endinterface

// File: rtl/i2s_tx.sv
// Stereo I2S-style serializer.
// A valid strobe in IDLE latches a left/right pair. The pair is shifted out MSB first,
// left-justified in SLOT_WIDTH-bit slots, with a generated bclk/lrck.
// A strobe that arrives while a frame is in flight is dropped and flagged on overrun.
module i2s_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 24,
  parameter int BCLK_HALF  = 2
) (
  input  logic     clk,
  input  logic     rst,     // asynchronous, active low
  i2s_tx_if.slave  bus
);

  localparam int BIT_W = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
  localparam int DIV_W = (BCLK_HALF  > 1) ? $clog2(BCLK_HALF)  : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  generate
    if (SLOT_WIDTH < DATA_WIDTH) begin : g_bad_slot
      $error("i2s_tx: SLOT_WIDTH must be >= DATA_WIDTH");
    end
    if (BCLK_HALF < 1) begin : g_bad_half
      $error("i2s_tx: BCLK_HALF must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  state_t                 state, state_nxt;
  logic [SLOT_WIDTH-1:0]  sh_l, sh_r;
  logic [SLOT_WIDTH-1:0]  sh_l_shift, sh_r_shift;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DIV_W-1:0]       div_cnt;
  logic                   bclk_q, lrck_q, sdata_q, ovr_q;
  logic                   load, fall, tick, last_bit;

  // Place a sample MSB-first in its slot. Unused low-order bits are zero padding.
  function automatic logic [SLOT_WIDTH-1:0] slot_align(input logic [DATA_WIDTH-1:0] s);
    return SLOT_WIDTH'(s) << (SLOT_WIDTH - DATA_WIDTH);
  endfunction

  assign sh_l_shift = sh_l << 1;
  assign sh_r_shift = sh_r << 1;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic. Also decodes the load and falling-edge strobes for the datapath.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    fall      = 1'b0;
    tick      = (div_cnt == DIV_LAST);
    last_bit  = (bit_cnt == BIT_LAST);
    case (state)
      IDLE: begin
        if (bus.valid) begin
          state_nxt = LEFT;
          load      = 1'b1;
        end
      end
      LEFT: begin
        if (tick && bclk_q) begin
          fall = 1'b1;
          if (last_bit) state_nxt = RIGHT;
        end
      end
      RIGHT: begin
        if (tick && bclk_q) begin
          fall = 1'b1;
          if (last_bit) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift registers, bit clock divider, serial outputs and overrun flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_l    <= '0;
      sh_r    <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      bclk_q  <= 1'b0;
      lrck_q  <= 1'b0;
      sdata_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      // A strobe outside IDLE is never accepted. Flag it for exactly one cycle.
      ovr_q <= bus.valid && (state != IDLE);
      if (load) begin
        sh_l    <= slot_align(bus.left_in);
        sh_r    <= slot_align(bus.right_in);
        sdata_q <= bus.left_in[DATA_WIDTH-1];
        bit_cnt <= '0;
        div_cnt <= '0;
        bclk_q  <= 1'b0;
        lrck_q  <= 1'b0;
      end else if (state != IDLE) begin
        if (tick) begin
          div_cnt <= '0;
          bclk_q  <= ~bclk_q;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        // sdata only moves on the bclk falling edge, so it is stable at every rise
        if (fall) begin
          bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
          if (state == LEFT) begin
            sh_l <= sh_l_shift;
            if (last_bit) begin
              lrck_q  <= 1'b1;
              sdata_q <= sh_r[SLOT_WIDTH-1];
            end else begin
              sdata_q <= sh_l_shift[SLOT_WIDTH-1];
            end
          end else begin
            if (last_bit) begin
              sh_r    <= '0;
              lrck_q  <= 1'b0;
              sdata_q <= 1'b0;
            end else begin
              sh_r    <= sh_r_shift;
              sdata_q <= sh_r_shift[SLOT_WIDTH-1];
            end
          end
        end
      end
    end
  end

  assign bus.ready   = (state == IDLE);
  assign bus.busy    = (state != IDLE);
  assign bus.bclk    = bclk_q;
  assign bus.lrck    = lrck_q;
  assign bus.sdata   = sdata_q;
  assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed testbench for i2s_tx.
// It runs three parameterizations: the defaults, zero-padded 16-in-24 slots,
// and a minimum divider with 16-bit slots.
module tb_i2s_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  i2s_tx_if #(.DATA_WIDTH(24)) b0 ();
  i2s_tx_if #(.DATA_WIDTH(16)) b1 ();
  i2s_tx_if #(.DATA_WIDTH(16)) b2 ();

  i2s_tx #(.DATA_WIDTH(24), .SLOT_WIDTH(24), .BCLK_HALF(2)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  i2s_tx #(.DATA_WIDTH(16), .SLOT_WIDTH(24), .BCLK_HALF(2)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  i2s_tx #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .BCLK_HALF(1)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  always #5 clk = ~clk;

  // Capture serial bits on each bclk rise. Count rises, left-slot rises, busy cycles and overrun cycles.
  logic [47:0] cap0 = '0;
  logic [47:0] cap1 = '0;
  logic [31:0] cap2 = '0;
  int rises0 = 0, low0 = 0, busy0 = 0, ovr0 = 0;
  int busy1 = 0, rises2 = 0, busy2 = 0;

  always @(posedge b0.bclk) begin
    cap0   <= {cap0[46:0], b0.sdata};
    rises0 <= rises0 + 1;
    if (!b0.lrck) low0 <= low0 + 1;
  end

  always @(posedge b1.bclk) cap1 <= {cap1[46:0], b1.sdata};

  always @(posedge b2.bclk) begin
    cap2   <= {cap2[30:0], b2.sdata};
    rises2 <= rises2 + 1;
  end

  always @(negedge clk) begin
    if (b0.busy)    busy0 <= busy0 + 1;
    if (b0.overrun) ovr0  <= ovr0 + 1;
    if (b1.busy)    busy1 <= busy1 + 1;
    if (b2.busy)    busy2 <= busy2 + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and land 1 ns after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle strobe on the default instance, sampled at the next rising edge
  task automatic pulse0(input logic [23:0] l, input logic [23:0] r);
    b0.left_in  = l;
    b0.right_in = r;
    b0.valid    = 1'b1;
    @(posedge clk);
    #1;
    b0.valid    = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin : main
    int rb0, lb0, bb0, ob0, bb1, rb2, bb2;
    b0.valid = 1'b0; b0.left_in = '0; b0.right_in = '0;
    b1.valid = 1'b0; b1.left_in = '0; b1.right_in = '0;
    b2.valid = 1'b0; b2.left_in = '0; b2.right_in = '0;

    // Reset values
    tick(3);
    chk("rst_bclk", b0.bclk, 1'b0);
    chk("rst_lrck", b0.lrck, 1'b0);
    chk("rst_sdata", b0.sdata, 1'b0);
    chk("rst_busy", b0.busy, 1'b0);
    chk("rst_ovr", b0.overrun, 1'b0);
    chk("rst_ready", b0.ready, 1'b1);
    rst = 1'b1;
    tick(2);

    // Single frame on all three instances
    rb0 = rises0; lb0 = low0; bb0 = busy0; ob0 = ovr0;
    bb1 = busy1; rb2 = rises2; bb2 = busy2;
    b1.left_in = 16'hFFFF; b1.right_in = 16'h8001; b1.valid = 1'b1;
    b2.left_in = 16'hBEEF; b2.right_in = 16'h1234; b2.valid = 1'b1;
    pulse0(24'hA5A5A5, 24'h5A5A5A);
    b1.valid = 1'b0;
    b2.valid = 1'b0;
    chk("f_busy", b0.busy, 1'b1);
    chk("f_ready", b0.ready, 1'b0);
    chk("f_msb", b0.sdata, 1'b1);
    chk("f_lrck", b0.lrck, 1'b0);
    chk("f_bclk0", b0.bclk, 1'b0);
    tick(1);
    chk("f_bclk_low", b0.bclk, 1'b0);
    chk("d_bclk_rise", b2.bclk, 1'b1);
    tick(1);
    chk("f_bclk_rise", b0.bclk, 1'b1);
    tick(61);
    chk("d_busy_end", b2.busy, 1'b1);
    tick(1);
    chk("d_ready", b2.ready, 1'b1);
    chk("d_data", cap2, 32'hBEEF1234);
    chk("d_rises", rises2 - rb2, 32);
    chk("d_busylen", busy2 - bb2, 64);
    tick(127);
    chk("f_busy_end", b0.busy, 1'b1);
    tick(1);
    chk("f_ready_end", b0.ready, 1'b1);
    chk("f_data", cap0, 48'hA5A5A5_5A5A5A);
    chk("f_rises", rises0 - rb0, 48);
    chk("f_left_rises", low0 - lb0, 24);
    chk("f_busylen", busy0 - bb0, 192);
    chk("f_no_ovr", ovr0 - ob0, 0);
    chk("p_data", cap1, 48'hFFFF00_800100);
    chk("p_busylen", busy1 - bb1, 192);
    chk("p_ready", b1.ready, 1'b1);

    // Overrun mid-frame: strobes at 0 and 100
    ob0 = ovr0;
    pulse0(24'h123ABC, 24'h0F0F0F);
    tick(99);
    pulse0(24'h123456, 24'h654321);
    chk("o_pulse", b0.overrun, 1'b1);
    tick(1);
    chk("o_pulse_end", b0.overrun, 1'b0);
    tick(90);
    chk("o_busy_end", b0.busy, 1'b1);
    tick(1);
    chk("o_ready", b0.ready, 1'b1);
    chk("o_data", cap0, 48'h123ABC_0F0F0F);
    chk("o_count", ovr0 - ob0, 1);

    // Back-to-back accepted: strobes at 0 and 193
    ob0 = ovr0;
    pulse0(24'hC0FFEE, 24'h00BEEF);
    tick(192);
    chk("b_ready", b0.ready, 1'b1);
    chk("b_data1", cap0, 48'hC0FFEE_00BEEF);
    pulse0(24'h13579B, 24'h2468AC);
    chk("b_busy2", b0.busy, 1'b1);
    chk("b_msb2", b0.sdata, 1'b0);
    chk("b_no_ovr_now", b0.overrun, 1'b0);
    tick(192);
    chk("b_ready2", b0.ready, 1'b1);
    chk("b_data2", cap0, 48'h13579B_2468AC);
    chk("b_no_ovr", ovr0 - ob0, 0);

    // Back-to-back dropped: strobes at 0 and 192
    ob0 = ovr0;
    pulse0(24'hFEDCBA, 24'h012345);
    tick(191);
    pulse0(24'h777777, 24'h777777);
    chk("x_ovr", b0.overrun, 1'b1);
    chk("x_ready", b0.ready, 1'b1);
    tick(5);
    chk("x_dropped", b0.busy, 1'b0);
    chk("x_data", cap0, 48'hFEDCBA_012345);
    chk("x_count", ovr0 - ob0, 1);

    // Asynchronous reset mid-frame, then a clean frame afterwards
    pulse0(24'hFFFFFF, 24'hFFFFFF);
    tick(50);
    chk("r_pre_bclk", b0.bclk, 1'b1);
    chk("r_pre_sdata", b0.sdata, 1'b1);
    rst = 1'b0;
    #1;
    chk("r_bclk", b0.bclk, 1'b0);
    chk("r_lrck", b0.lrck, 1'b0);
    chk("r_sdata", b0.sdata, 1'b0);
    chk("r_busy", b0.busy, 1'b0);
    chk("r_ovr", b0.overrun, 1'b0);
    tick(2);
    rst = 1'b1;
    tick(2);
    pulse0(24'h800001, 24'h000000);
    chk("r2_msb", b0.sdata, 1'b1);
    tick(192);
    chk("r2_ready", b0.ready, 1'b1);
    chk("r2_data", cap0, 48'h800001_000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
